// File: rtl/iterative_divider_param.sv
// Restoring sequential divider producing one quotient bit per clock, with
// optional signed (truncating) mode, remainder output and divide-by-zero flag.
module iterative_divider_param #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] divider__lhs,
    input  logic             divider__lhs_vld,
    output logic             divider__lhs_rdy,
    input  logic [WIDTH-1:0] divider__rhs,
    input  logic             divider__rhs_vld,
    output logic             divider__rhs_rdy,
    output logic [WIDTH-1:0] divider__result,
    output logic [WIDTH-1:0] divider__rem,
    output logic             divider__div_zero,
    output logic             divider__result_vld,
    input  logic             divider__result_rdy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam bit SGN = (SIGNED != 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic             lhs_neg, rhs_neg;
    logic [WIDTH-1:0] lhs_mag, rhs_mag;
    logic [WIDTH:0]   trial, diff, step_prem;
    logic             step_ge;
    logic [WIDTH-1:0] step_quo;

    assign accept  = (state_q == ST_IDLE) && divider__lhs_vld && divider__rhs_vld;
    assign lhs_neg = SGN && divider__lhs[WIDTH-1];
    assign rhs_neg = SGN && divider__rhs[WIDTH-1];
    assign lhs_mag = lhs_neg ? -divider__lhs : divider__lhs;
    assign rhs_mag = rhs_neg ? -divider__rhs : divider__rhs;

    // One restoring step: quo_q doubles as the dividend shift register
    assign trial     = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign diff      = trial - {1'b0, dvs_q};
    assign step_ge   = (trial >= {1'b0, dvs_q});
    assign step_prem = step_ge ? diff : trial;
    assign step_quo  = {quo_q[WIDTH-2:0], step_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        res_d   = res_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    prem_d  = '0;
                    quo_d   = lhs_mag;
                    dvs_d   = rhs_mag;
                    negq_d  = lhs_neg ^ rhs_neg;
                    negr_d  = lhs_neg;
                    zero_d  = (divider__rhs == '0);
                    cnt_d   = CW'(WIDTH);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Zero divisor spends a single BUSY cycle so results land one edge after accept
                if (zero_q) begin
                    res_d   = SGN ? (negr_q ? MIN_NEG : MAX_POS) : '1;
                    rem_d   = negr_q ? -quo_q : quo_q;
                    dz_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    prem_d = step_prem;
                    quo_d  = step_quo;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        res_d   = negq_q ? -step_quo : step_quo;
                        rem_d   = negr_q ? -step_prem[WIDTH-1:0] : step_prem[WIDTH-1:0];
                        dz_d    = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (divider__result_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            res_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign divider__lhs_rdy    = (state_q == ST_IDLE) && divider__rhs_vld && !rst;
    assign divider__rhs_rdy    = (state_q == ST_IDLE) && divider__lhs_vld && !rst;
    assign divider__result_vld = (state_q == ST_DONE);
    assign divider__result     = res_q;
    assign divider__rem        = rem_q;
    assign divider__div_zero   = dz_q;

endmodule
